arf_wb_sched: RTL and testbench
===============================

// Module: arf_wb_sched
// PURPOSE
//  Write-back scheduler in front of the dual-write-port ARF. Buffers in-order commit results from
//  ROB retirement (up to 2 per cycle) in a small FIFO and drains up to 2 per cycle onto ARF write
//  ports 0/1 (oldest->port0, younger->port1, so port1 priority = program order on equal addresses).
//  Forwards still-queued results to the 4 ARF read ports so readers never see stale data.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >=4
//  AW      5   register address width
//  DW      32  register data width
// PORTS
//  clk          in   1      clock; all state on posedge
//  reset        in   1      synchronous, active-high
//  in_valid     in   2      commit lanes; lane0 older; in_valid[1] only legal with in_valid[0]
//  in_addr0/1   in   AW     destination register per lane
//  in_data0/1   in   DW     result per lane
//  in_ready     out  1      1 = FIFO can take 2 entries this cycle
//  hold         in   1      1 = suspend draining (debug/exception freeze)
//  waddr0/1     out  AW     to ARF write ports
//  wen0/1       out  1
//  wdata0/1     out  DW
//  fwd_addr0..3 in   AW     copies of ARF raddr0..3
//  fwd_hit0..3  out  1      1 = newest queued write to that address exists
//  fwd_data0..3 out  DW     data of that newest queued write
//  empty        out  1      FIFO empty
// BEHAVIOUR
//  - Reset: rd/wr pointers and count = 0; wen0/1=0, in_ready=1, empty=1, fwd_hit*=0 next cycle.
//    Reset mid-operation discards all queued entries; no write issued in the reset cycle.
//  - Pointers AW_PTR=log2(DEPTH)+1 bits, wrap naturally; count = wr_ptr - rd_ptr.
//  - in_ready = (count <= DEPTH-2), from registered count only (no path from hold/drain).
//  - Enqueue on edge when in_ready & in_valid[0]: lane0 at wr_ptr, lane1 at wr_ptr+1 if valid;
//    wr_ptr += popcount(in_valid). in_valid ignored when in_ready=0 (producer must hold).
//  - Drain (combinational from head): n = hold ? 0 : min(count,2). Slot rd_ptr -> port0,
//    rd_ptr+1 -> port1. wen_k = (k<n) & (addr!=0); addr-0 entries still popped, never written.
//    rd_ptr += n on edge. Latency: enqueue at edge t -> ARF updated at edge t+1 (hold=0, empty).
//  - Simultaneous enqueue+drain in one cycle: both apply; count' = count + pushed - n.
//  - Equal addresses in one drain pair: both wen asserted; ARF port1 wins -> younger value.
//  - Forwarding: per query, search all valid entries (incl. those draining this cycle) newest
//    to oldest; hit on first address match; addr 0 never hits. Pure combinational.
//  - count==1: port0 only. count==DEPTH: in_ready=0, drain continues unless hold.
// STRUCTURE
//  - Package arf_pkg: ARF_AW, ARF_DW, typedef arf_wr_t {addr, data}, helper clog2 function.
//  - Sub-module arf_fwd_cam: DEPTH entries + valid mask + head ptr -> per-query newest-match
//    hit/data; instantiated 4 times (one per read port). FIFO/pointer logic stays in top.
// TESTING
//  1 Reset held 2 cycles -> wen0=wen1=0, in_ready=1, empty=1, all fwd_hit=0.
//  2 Lane0 r3=0x1111_1111 at edge t -> cycle t: fwd_hit for raddr 3, data 0x1111_1111;
//    wen0=1 waddr0=3; after edge t+1 empty=1, fwd_hit=0.
//  3 Pair r5=0xA (lane0), r5=0xB (lane1) -> wen0&wen1 both addr 5, wdata0=0xA, wdata1=0xB;
//    fwd_data=0xB; ARF r5 reads 0xB afterwards.
//  4 DEPTH=8, hold=1, push 4 pairs r1..r8 -> count 8, in_ready=0; drop hold -> pairs
//    (r1,r2),(r3,r4),(r5,r6),(r7,r8) written on 4 consecutive edges, then empty=1.
//  5 Commit to r0 with 0xDEAD -> popped next edge with wen0=0; fwd query r0 hit=0.
//  6 5 entries queued, hold=1, assert reset 1 cycle -> no wen, next cycle empty=1, in_ready=1,
//    fwd_hit=0 for all previously queued addresses.

Source files
------------

// File: rtl/arf_pkg.sv
// rtl/arf_pkg.sv - shared widths, write record type and sizing helper for the ARF write-back path
package arf_pkg;

   localparam int ARF_AW = 5;
   localparam int ARF_DW = 32;

   typedef struct packed {
      logic [ARF_AW-1:0] addr;
      logic [ARF_DW-1:0] data;
   } arf_wr_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/arf_fwd_cam.sv
// rtl/arf_fwd_cam.sv - newest-match lookup of one read address against the queued write-back entries
module arf_fwd_cam
   import arf_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = ARF_AW,
   parameter int DW    = ARF_DW,
   localparam int IW   = clog2(DEPTH)
) (
   input  logic [AW-1:0]    ent_addr [DEPTH],
   input  logic [DW-1:0]    ent_data [DEPTH],
   input  logic [DEPTH-1:0] ent_valid,
   input  logic [IW-1:0]    head,
   input  logic [AW-1:0]    q_addr,
   output logic             hit,
   output logic [DW-1:0]    data
);

   logic [IW-1:0] idx;

   // Walk oldest to newest from the head so a later match overrides an earlier one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + IW'(k);
         if (ent_valid[idx] && (ent_addr[idx] == q_addr) && (q_addr != '0)) begin
            hit  = 1'b1;
            data = ent_data[idx];
         end
      end
   end

endmodule

// File: rtl/arf_wb_sched.sv
// rtl/arf_wb_sched.sv - commit FIFO draining onto two ARF write ports with read-port forwarding
module arf_wb_sched
   import arf_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = ARF_AW,
   parameter int DW    = ARF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    in_valid,
   input  logic [AW-1:0] in_addr0,
   input  logic [AW-1:0] in_addr1,
   input  logic [DW-1:0] in_data0,
   input  logic [DW-1:0] in_data1,
   output logic          in_ready,
   input  logic          hold,
   output logic [AW-1:0] waddr0,
   output logic [AW-1:0] waddr1,
   output logic          wen0,
   output logic          wen1,
   output logic [DW-1:0] wdata0,
   output logic [DW-1:0] wdata1,
   input  logic [AW-1:0] fwd_addr0,
   input  logic [AW-1:0] fwd_addr1,
   input  logic [AW-1:0] fwd_addr2,
   input  logic [AW-1:0] fwd_addr3,
   output logic          fwd_hit0,
   output logic          fwd_hit1,
   output logic          fwd_hit2,
   output logic          fwd_hit3,
   output logic [DW-1:0] fwd_data0,
   output logic [DW-1:0] fwd_data1,
   output logic [DW-1:0] fwd_data2,
   output logic [DW-1:0] fwd_data3,
   output logic          empty
);

   localparam int IW = clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    mem_addr_q [DEPTH];
   logic [AW-1:0]    mem_addr_d [DEPTH];
   logic [DW-1:0]    mem_data_q [DEPTH];
   logic [DW-1:0]    mem_data_d [DEPTH];

   logic [PW-1:0]    count;
   logic             push;
   logic [PW-1:0]    n_push;
   logic [PW-1:0]    n_drain;
   logic [IW-1:0]    wr_idx0, wr_idx1;
   logic [IW-1:0]    rd_idx0, rd_idx1;
   logic [DEPTH-1:0] ent_valid;
   logic [IW-1:0]    offset;

   assign count    = wr_ptr_q - rd_ptr_q;
   assign in_ready = (count <= PW'(DEPTH - 2));
   assign empty    = (count == '0);

   assign wr_idx0 = wr_ptr_q[IW-1:0];
   assign wr_idx1 = wr_ptr_q[IW-1:0] + IW'(1);
   assign rd_idx0 = rd_ptr_q[IW-1:0];
   assign rd_idx1 = rd_ptr_q[IW-1:0] + IW'(1);

   assign push   = in_ready & in_valid[0];
   assign n_push = push ? (in_valid[1] ? PW'(2) : PW'(1)) : '0;

   always_comb begin
      n_drain = '0;
      if (!hold) n_drain = (count >= PW'(2)) ? PW'(2) : count;
   end

   // Address-0 entries are still popped; only the write enable is suppressed.
   assign waddr0 = mem_addr_q[rd_idx0];
   assign waddr1 = mem_addr_q[rd_idx1];
   assign wdata0 = mem_data_q[rd_idx0];
   assign wdata1 = mem_data_q[rd_idx1];
   assign wen0   = !reset && (n_drain >= PW'(1)) && (waddr0 != '0);
   assign wen1   = !reset && (n_drain == PW'(2)) && (waddr1 != '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + n_push;
      rd_ptr_d   = rd_ptr_q + n_drain;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      if (push) begin
         mem_addr_d[wr_idx0] = in_addr0;
         mem_data_d[wr_idx0] = in_data0;
         if (in_valid[1]) begin
            mem_addr_d[wr_idx1] = in_addr1;
            mem_data_d[wr_idx1] = in_data1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload needs no reset: the valid mask derived from the pointers gates every use.
   always_ff @(posedge clk) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

   always_comb begin
      ent_valid = '0;
      offset    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset       = IW'(i) - rd_idx0;
         ent_valid[i] = ({1'b0, offset} < count);
      end
   end

   arf_fwd_cam #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_cam0 (
      .ent_addr(mem_addr_q), .ent_data(mem_data_q), .ent_valid(ent_valid),
      .head(rd_idx0), .q_addr(fwd_addr0), .hit(fwd_hit0), .data(fwd_data0)
   );

   arf_fwd_cam #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_cam1 (
      .ent_addr(mem_addr_q), .ent_data(mem_data_q), .ent_valid(ent_valid),
      .head(rd_idx0), .q_addr(fwd_addr1), .hit(fwd_hit1), .data(fwd_data1)
   );

   arf_fwd_cam #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_cam2 (
      .ent_addr(mem_addr_q), .ent_data(mem_data_q), .ent_valid(ent_valid),
      .head(rd_idx0), .q_addr(fwd_addr2), .hit(fwd_hit2), .data(fwd_data2)
   );

   arf_fwd_cam #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_cam3 (
      .ent_addr(mem_addr_q), .ent_data(mem_data_q), .ent_valid(ent_valid),
      .head(rd_idx0), .q_addr(fwd_addr3), .hit(fwd_hit3), .data(fwd_data3)
   );

endmodule

// File: tb/tb_arf_wb_sched.sv
// tb/tb_arf_wb_sched.sv - directed self-checking bench for the ARF write-back scheduler
module tb_arf_wb_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  in_valid;
   logic [4:0]  in_addr0, in_addr1;
   logic [31:0] in_data0, in_data1;
   logic        in_ready;
   logic        hold;
   logic [4:0]  waddr0, waddr1;
   logic        wen0, wen1;
   logic [31:0] wdata0, wdata1;
   logic [4:0]  fa0, fa1, fa2, fa3;
   logic        fh0, fh1, fh2, fh3;
   logic [31:0] fd0, fd1, fd2, fd3;
   logic        empty;

   logic [31:0] arf [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   arf_wb_sched #(.DEPTH(8), .AW(5), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_addr0(in_addr0), .in_addr1(in_addr1),
      .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready),
      .hold(hold),
      .waddr0(waddr0), .waddr1(waddr1), .wen0(wen0), .wen1(wen1),
      .wdata0(wdata0), .wdata1(wdata1),
      .fwd_addr0(fa0), .fwd_addr1(fa1), .fwd_addr2(fa2), .fwd_addr3(fa3),
      .fwd_hit0(fh0), .fwd_hit1(fh1), .fwd_hit2(fh2), .fwd_hit3(fh3),
      .fwd_data0(fd0), .fwd_data1(fd1), .fwd_data2(fd2), .fwd_data3(fd3),
      .empty(empty)
   );

   // Register-file model: port1 is applied after port0, so it wins on equal addresses.
   always @(posedge clk) begin
      if (wen0) arf[waddr0] <= wdata0;
      if (wen1) arf[waddr1] <= wdata1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
      in_valid = v;
      in_addr0 = a0;
      in_data0 = d0;
      in_addr1 = a1;
      in_data1 = d1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) arf[i] = '0;
      reset = 1'b1;
      hold  = 1'b0;
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      fa0 = 5'd1; fa1 = 5'd2; fa2 = 5'd3; fa3 = 5'd4;

      // 1: reset state
      tick();
      tick();
      check_eq("rst_wen0", {31'b0, wen0}, 32'd0);
      check_eq("rst_wen1", {31'b0, wen1}, 32'd0);
      check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check_eq("rst_empty", {31'b0, empty}, 32'd1);
      check_eq("rst_fwd_hits", {28'b0, fh0, fh1, fh2, fh3}, 32'd0);
      reset = 1'b0;

      // 2: single lane0 commit, forwarded then written one edge later
      push(2'b01, 5'd3, 32'h1111_1111, 5'd0, 32'h0);
      tick();
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      fa0 = 5'd3;
      #1;
      check_eq("t2_fwd_hit", {31'b0, fh0}, 32'd1);
      check_eq("t2_fwd_data", fd0, 32'h1111_1111);
      check_eq("t2_wen0", {31'b0, wen0}, 32'd1);
      check_eq("t2_waddr0", {27'b0, waddr0}, 32'd3);
      check_eq("t2_wdata0", wdata0, 32'h1111_1111);
      check_eq("t2_wen1_count1", {31'b0, wen1}, 32'd0);
      tick();
      check_eq("t2_empty", {31'b0, empty}, 32'd1);
      check_eq("t2_fwd_hit_after", {31'b0, fh0}, 32'd0);
      check_eq("t2_arf_r3", arf[3], 32'h1111_1111);

      // 3: same address in one pair, younger value must win
      push(2'b11, 5'd5, 32'hA, 5'd5, 32'hB);
      tick();
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      fa1 = 5'd5;
      #1;
      check_eq("t3_wens", {30'b0, wen0, wen1}, 32'd3);
      check_eq("t3_waddrs", {22'b0, waddr0, waddr1}, {22'b0, 5'd5, 5'd5});
      check_eq("t3_wdata0", wdata0, 32'hA);
      check_eq("t3_wdata1", wdata1, 32'hB);
      check_eq("t3_fwd_data", fd1, 32'hB);
      tick();
      check_eq("t3_arf_r5", arf[5], 32'hB);

      // 4: fill to DEPTH under hold, ignore input while full, then drain in pairs
      hold = 1'b1;
      for (int p = 0; p < 4; p++) begin
         check_eq("t4_ready_fill", {31'b0, in_ready}, 32'd1);
         push(2'b11, 5'(2 * p + 1), 32'h100 + 32'(2 * p + 1), 5'(2 * p + 2), 32'h100 + 32'(2 * p + 2));
         tick();
      end
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      fa2 = 5'd8;
      #1;
      check_eq("t4_full_ready", {31'b0, in_ready}, 32'd0);
      check_eq("t4_hold_wen", {30'b0, wen0, wen1}, 32'd0);
      check_eq("t4_fwd_r8", {fh2, fd2[30:0]}, {1'b1, 31'h108});
      push(2'b01, 5'd9, 32'h999, 5'd0, 32'h0);
      tick();
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      check_eq("t4_still_full", {31'b0, in_ready}, 32'd0);
      hold = 1'b0;
      #1;
      for (int p = 0; p < 4; p++) begin
         check_eq("t4_drain_wens", {30'b0, wen0, wen1}, 32'd3);
         check_eq("t4_drain_waddr0", {27'b0, waddr0}, 32'(2 * p + 1));
         check_eq("t4_drain_waddr1", {27'b0, waddr1}, 32'(2 * p + 2));
         check_eq("t4_drain_wdata1", wdata1, 32'h100 + 32'(2 * p + 2));
         tick();
         if (p == 0) check_eq("t4_ready_after1", {31'b0, in_ready}, 32'd1);
      end
      check_eq("t4_empty", {31'b0, empty}, 32'd1);
      check_eq("t4_arf_r8", arf[8], 32'h108);
      check_eq("t4_arf_r9_untouched", arf[9], 32'h0);

      // 5: address 0 is popped but never written or forwarded
      push(2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0);
      tick();
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      fa3 = 5'd0;
      #1;
      check_eq("t5_nonempty", {31'b0, empty}, 32'd0);
      check_eq("t5_wen0", {31'b0, wen0}, 32'd0);
      check_eq("t5_fwd_r0", {31'b0, fh3}, 32'd0);
      tick();
      check_eq("t5_empty", {31'b0, empty}, 32'd1);
      check_eq("t5_arf_r0", arf[0], 32'h0);

      // simultaneous enqueue and drain
      push(2'b11, 5'd20, 32'h20, 5'd21, 32'h21);
      tick();
      push(2'b11, 5'd22, 32'h22, 5'd23, 32'h23);
      #1;
      check_eq("sim_waddr0_first", {27'b0, waddr0}, 32'd20);
      tick();
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check_eq("sim_waddr0_second", {27'b0, waddr0}, 32'd22);
      check_eq("sim_wdata1_second", wdata1, 32'h23);
      tick();
      check_eq("sim_empty", {31'b0, empty}, 32'd1);

      // 6: reset with 5 queued entries discards everything
      hold = 1'b1;
      push(2'b11, 5'd10, 32'hA10, 5'd11, 32'hA11);
      tick();
      push(2'b11, 5'd12, 32'hA12, 5'd13, 32'hA13);
      tick();
      push(2'b01, 5'd14, 32'hA14, 5'd0, 32'h0);
      tick();
      push(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      fa0 = 5'd10; fa1 = 5'd11; fa2 = 5'd12; fa3 = 5'd14;
      #1;
      check_eq("t6_pre_hits", {28'b0, fh0, fh1, fh2, fh3}, 32'hF);
      check_eq("t6_pre_ready", {31'b0, in_ready}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("t6_rst_wen", {30'b0, wen0, wen1}, 32'd0);
      tick();
      reset = 1'b0;
      hold  = 1'b0;
      #1;
      check_eq("t6_empty", {31'b0, empty}, 32'd1);
      check_eq("t6_ready", {31'b0, in_ready}, 32'd1);
      check_eq("t6_hits", {28'b0, fh0, fh1, fh2, fh3}, 32'd0);
      check_eq("t6_wen", {30'b0, wen0, wen1}, 32'd0);
      tick();
      check_eq("t6_arf_r10", arf[10], 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
